mu_regbank_arbiter: RTL and testbench

Round-robin write arbiter and storage for a small bank of D-flip-flop registers in the memory unit. Up to NREQ requesters compete for a single write port; the block grants one requester at a time, performs the write, and advances priority so no requester starves. A combinational read port exposes the bank contents to the datapath.

---
 rtl/mu_regbank_arbiter.sv | 137 +++++++++++++
 tb/tb_mu_regbank_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_regbank_arbiter.sv
// Round-robin write arbiter in front of a bank of 2**AW flip-flop registers with a combinational read port.
// Define MU_ARB_LOCK_EN to let the owner hold the grant for bursts of up to MAX_BURST writes.
//
// state | meaning
// IDLE  | no owner; choose the next requester from ptr upward
// GRANT | owner's write port is live; write happens if its req is still high
module mu_regbank_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] waddr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    input  logic [AW-1:0]      raddr,
    output logic [DW-1:0]      rdata
);

    localparam int IW   = $clog2(NREQ);
    localparam int NREG = 2**AW;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic [NREQ-1:0] gnt_nxt;
    logic            hold;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   bank [NREG];

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

`ifdef MU_ARB_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt, burst_nxt;

    // burst_cnt counts writes already done in this grant beyond the first
    assign hold = req[owner] && lock[owner] && (burst_cnt < BW'(MAX_BURST - 1));
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign hold        = 1'b0;
`endif

    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_req && req[wrap_idx(ptr, i)]) begin
                any_req = 1'b1;
                winner  = wrap_idx(ptr, i);
            end
        end
    end

    assign wr_en   = (state == GRANT) && req[owner];
    assign wr_addr = waddr[int'(owner)*AW +: AW];
    assign wr_data = wdata[int'(owner)*DW +: DW];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        owner_nxt = owner;
`ifdef MU_ARB_LOCK_EN
        burst_nxt = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NREQ'(1) << winner;
                    owner_nxt = winner;
`ifdef MU_ARB_LOCK_EN
                    burst_nxt = '0;
`endif
                end else begin
                    gnt_nxt = '0;
                end
            end
            GRANT: begin
                if (hold) begin
`ifdef MU_ARB_LOCK_EN
                    burst_nxt = burst_cnt + 1'b1;
`endif
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = wrap_idx(owner, 1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            owner <= '0;
`ifdef MU_ARB_LOCK_EN
            burst_cnt <= '0;
`endif
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            busy  <= (state_nxt == GRANT);
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
`ifdef MU_ARB_LOCK_EN
            burst_cnt <= burst_nxt;
`endif
            if (wr_en) bank[wr_addr] <= wr_data;
        end
    end

    assign rdata = bank[raddr];

endmodule

// File: tb/tb_mu_regbank_arbiter.sv
// Self-checking bench for mu_regbank_arbiter: expected grants go into a queue when requests
// are driven and are popped when the DUT raises gnt; a reference copy of the bank tracks writes.
module tb_mu_regbank_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] waddr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [AW-1:0]      raddr;
    logic [DW-1:0]      rdata;

    int errors = 0;
    int checks = 0;
    logic [NREQ-1:0] gnt_q [$];
    logic [NREQ-1:0] exp_gnt;
    logic [DW-1:0]   model_bank [2**AW];

    mu_regbank_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .waddr (waddr),
        .wdata (wdata),
        .gnt   (gnt),
        .busy  (busy),
        .raddr (raddr),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < 2**AW; a++) model_bank[a] = '0;
    endtask

    task automatic test_reset();
        waddr = '0;
        wdata = '0;
        raddr = '0;
        do_reset();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        for (int a = 0; a < 2**AW; a++) begin
            raddr = AW'(a);
            #1;
            checks++;
            if (rdata !== model_bank[a]) begin
                errors++; $display("FAIL reset_rdata[%0d]: got %h want %h", a, rdata, model_bank[a]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_slot(2, 3'd5, 8'hA5);
        req = 4'b0100;
        gnt_q.push_back(4'b0100);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL single_gnt: got %b want %b", gnt, exp_gnt); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        model_bank[5] = 8'hA5;
        req = 4'b0000;
        raddr = 3'd5;
        #1;
        checks++;
        if (rdata !== model_bank[5]) begin errors++; $display("FAIL single_rdata: got %h want %h", rdata, model_bank[5]); end
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        // ptr now sits at 3, so 3 must beat 0
        set_slot(0, 3'd0, 8'h0F);
        set_slot(3, 3'd3, 8'h33);
        req = 4'b1001;
        gnt_q.push_back(4'b1000);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL single_ptr_gnt: got %b want %b", gnt, exp_gnt); end
        tick();
        model_bank[3] = 8'h33;
        req = 4'b0001;
        raddr = 3'd3;
        #1;
        checks++;
        if (rdata !== model_bank[3]) begin errors++; $display("FAIL single_ptr_rdata: got %h want %h", rdata, model_bank[3]); end
        gnt_q.push_back(4'b0001);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL single_wrap_gnt: got %b want %b", gnt, exp_gnt); end
        tick();
        model_bank[0] = 8'h0F;
        req = 4'b0000;
        raddr = 3'd0;
        #1;
        checks++;
        if (rdata !== model_bank[0]) begin errors++; $display("FAIL single_wrap_rdata: got %h want %h", rdata, model_bank[0]); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d [NREQ];
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            d[k] = DW'(8'h10 + k);
            set_slot(k, AW'(k + 2), d[k]);
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) gnt_q.push_back(NREQ'(1) << (n % NREQ));
        for (int n = 0; n < 5; n++) begin
            int k;
            k = n % NREQ;
            tick();
            exp_gnt = gnt_q.pop_front();
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, exp_gnt); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy[%0d]: got %b want 1", n, busy); end
            tick();
            model_bank[k + 2] = d[k];
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL rr_gap[%0d]: got gnt=%b busy=%b want 0000/0", n, gnt, busy);
            end
            raddr = AW'(k + 2);
            #1;
            checks++;
            if (rdata !== model_bank[k + 2]) begin
                errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", n, rdata, model_bank[k + 2]);
            end
            d[k] = d[k] + 8'h40;
            set_slot(k, AW'(k + 2), d[k]);
        end
        req = 4'b0000;
    endtask

    task automatic test_abort();
        do_reset();
        set_slot(1, 3'd6, 8'h66);
        set_slot(2, 3'd2, 8'h22);
        req = 4'b0110;
        gnt_q.push_back(4'b0010);
        gnt_q.push_back(4'b0100);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL abort_gnt1: got %b want %b", gnt, exp_gnt); end
        req = 4'b0100;
        tick();
        raddr = 3'd6;
        #1;
        checks++;
        if (rdata !== model_bank[6]) begin errors++; $display("FAIL abort_nowrite: got %h want %h", rdata, model_bank[6]); end
        raddr = 3'd2;
        #1;
        checks++;
        if (rdata !== model_bank[2]) begin errors++; $display("FAIL abort_other: got %h want %h", rdata, model_bank[2]); end
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL abort_gnt2: got %b want %b", gnt, exp_gnt); end
        tick();
        model_bank[2] = 8'h22;
        req = 4'b0000;
        #1;
        checks++;
        if (rdata !== model_bank[2]) begin errors++; $display("FAIL abort_rdata2: got %h want %h", rdata, model_bank[2]); end
    endtask

    task automatic test_reset_in_grant();
        do_reset();
        set_slot(0, 3'd7, 8'h3C);
        req = 4'b0001;
        gnt_q.push_back(4'b0001);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL rst_grant_gnt: got %b want %b", gnt, exp_gnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_grant_out: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        raddr = 3'd7;
        #1;
        checks++;
        if (rdata !== model_bank[7]) begin errors++; $display("FAIL rst_grant_rdata: got %h want %h", rdata, model_bank[7]); end
    endtask

`ifdef MU_ARB_LOCK_EN
    task automatic test_lock_burst();
        do_reset();
        set_slot(0, 3'd4, 8'hB0);
        set_slot(1, 3'd1, 8'h11);
        req  = 4'b0011;
        lock = 4'b0001;
        gnt_q.push_back(4'b0001);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL lock_gnt0: got %b want %b", gnt, exp_gnt); end
        raddr = 3'd4;
        for (int b = 0; b < 4; b++) begin
            tick();
            model_bank[4] = DW'(8'hB0 + b);
            checks++;
            if (rdata !== model_bank[4]) begin errors++; $display("FAIL lock_rdata[%0d]: got %h want %h", b, rdata, model_bank[4]); end
            if (b < 3) begin
                checks++;
                if (gnt !== 4'b0001 || busy !== 1'b1) begin
                    errors++; $display("FAIL lock_hold[%0d]: got gnt=%b busy=%b want 0001/1", b, gnt, busy);
                end
                set_slot(0, 3'd4, DW'(8'hB0 + b + 1));
            end else begin
                checks++;
                if (gnt !== 4'b0000 || busy !== 1'b0) begin
                    errors++; $display("FAIL lock_end: got gnt=%b busy=%b want 0000/0", gnt, busy);
                end
            end
        end
        req  = 4'b0010;
        lock = 4'b0000;
        gnt_q.push_back(4'b0010);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL lock_next_gnt: got %b want %b", gnt, exp_gnt); end
        tick();
        model_bank[1] = 8'h11;
        req = 4'b0000;
        raddr = 3'd1;
        #1;
        checks++;
        if (rdata !== model_bank[1]) begin errors++; $display("FAIL lock_next_rdata: got %h want %h", rdata, model_bank[1]); end
    endtask
`else
    task automatic test_lock_ignored();
        do_reset();
        set_slot(0, 3'd4, 8'hB0);
        set_slot(1, 3'd1, 8'h11);
        req  = 4'b0011;
        lock = 4'b0001;
        gnt_q.push_back(4'b0001);
        gnt_q.push_back(4'b0010);
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL nolock_gnt0: got %b want %b", gnt, exp_gnt); end
        tick();
        model_bank[4] = 8'hB0;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL nolock_single: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        raddr = 3'd4;
        #1;
        checks++;
        if (rdata !== model_bank[4]) begin errors++; $display("FAIL nolock_rdata: got %h want %h", rdata, model_bank[4]); end
        tick();
        exp_gnt = gnt_q.pop_front();
        checks++;
        if (gnt !== exp_gnt) begin errors++; $display("FAIL nolock_next_gnt: got %b want %b", gnt, exp_gnt); end
        tick();
        req  = 4'b0000;
        lock = 4'b0000;
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_reset_in_grant();
`ifdef MU_ARB_LOCK_EN
        test_lock_burst();
`else
        test_lock_ignored();
`endif
        checks++;
        if (gnt_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", gnt_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
